// File: rtl/key_sched_pkg.sv
// rtl/key_sched_pkg.sv - shared types and constants for the AES-128 round-key sequencer
package key_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        READY = 2'd3
    } state_t;

    localparam int AES_NR = 10;
    localparam int KEY_W  = 128;
    localparam int IDX_W  = 4;

endpackage

// File: rtl/key_sched_ctrl_key_bank.sv
// rtl/key_sched_ctrl_key_bank.sv - round-key register file, one write port, one registered read port
module key_bank
    import key_sched_pkg::*;
#(
    parameter int DEPTH = AES_NR + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [KEY_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [KEY_W-1:0] rd_data,
    output logic             rd_valid
);

    logic [KEY_W-1:0] mem_q [DEPTH];
    logic [KEY_W-1:0] mem_d [DEPTH];
    logic [KEY_W-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_idx] = wr_data;
        end
    end

    // Caller only raises rd_en for in-range indices; a dropped request reads as zero.
    always_comb begin
        rd_valid_d = rd_en;
        rd_data_d  = '0;
        if (rd_en) begin
            rd_data_d = mem_q[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: rtl/key_sched_ctrl.sv
// rtl/key_sched_ctrl.sv - AES-128 key expansion sequencer with round-key bank; KEY_SCHED_DECRYPT_EN adds rk_rev
module key_sched_ctrl
    import key_sched_pkg::*;
#(
    parameter int KX_LAT = 1,
    parameter int NR     = AES_NR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             done,
    output logic             keys_valid,
    output logic [KEY_W-1:0] kx_key,
    output logic [IDX_W-1:0] kx_times,
    input  logic [KEY_W-1:0] kx_keyout,
    input  logic             rk_rd_en,
    input  logic [IDX_W-1:0] rk_rd_idx,
`ifdef KEY_SCHED_DECRYPT_EN
    input  logic             rk_rev,
`endif
    output logic [KEY_W-1:0] rk_rd_data,
    output logic             rk_rd_valid
);

    localparam int WAIT_W = (KX_LAT < 1) ? 1 : $clog2(KX_LAT + 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   round_q, round_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               keys_valid_q, keys_valid_d;
    logic [KEY_W-1:0]   kx_key_q, kx_key_d;
    logic [IDX_W-1:0]   kx_times_q, kx_times_d;

    logic               bank_wr_en;
    logic [IDX_W-1:0]   bank_wr_idx;
    logic [KEY_W-1:0]   bank_wr_data;
    logic               rd_idx_ok;
    logic [IDX_W-1:0]   rd_idx_eff;

    always_comb begin
        state_d      = state_q;
        round_d      = round_q;
        wait_d       = wait_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        keys_valid_d = keys_valid_q;
        kx_key_d     = kx_key_q;
        kx_times_d   = kx_times_q;
        bank_wr_en   = 1'b0;
        bank_wr_idx  = round_q;
        bank_wr_data = kx_keyout;
        case (state_q)
            IDLE, READY: begin
                if (start) begin
                    bank_wr_en   = 1'b1;
                    bank_wr_idx  = '0;
                    bank_wr_data = key_in;
                    kx_key_d     = key_in;
                    kx_times_d   = IDX_W'(1);
                    round_d      = IDX_W'(1);
                    wait_d       = '0;
                    busy_d       = 1'b1;
                    keys_valid_d = 1'b0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                // Hold each round for KX_LAT cycles so the datapath output has settled before capture.
                if (wait_q < WAIT_W'(KX_LAT)) begin
                    wait_d = wait_q + 1'b1;
                end else begin
                    bank_wr_en = 1'b1;
                    kx_key_d   = kx_keyout;
                    wait_d     = '0;
                    if (round_q == IDX_W'(NR)) begin
                        kx_times_d   = '0;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                        keys_valid_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        round_d    = round_q + 1'b1;
                        kx_times_d = round_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = READY;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            round_q      <= '0;
            wait_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            kx_key_q     <= '0;
            kx_times_q   <= '0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            wait_q       <= wait_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            keys_valid_q <= keys_valid_d;
            kx_key_q     <= kx_key_d;
            kx_times_q   <= kx_times_d;
        end
    end

    // Range check uses the raw index; reversal only remaps an already-legal index.
    assign rd_idx_ok = (rk_rd_idx <= IDX_W'(NR));
`ifdef KEY_SCHED_DECRYPT_EN
    assign rd_idx_eff = rk_rev ? (IDX_W'(NR) - rk_rd_idx) : rk_rd_idx;
`else
    assign rd_idx_eff = rk_rd_idx;
`endif

    key_bank #(
        .DEPTH (NR + 1)
    ) u_key_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (bank_wr_en),
        .wr_idx   (bank_wr_idx),
        .wr_data  (bank_wr_data),
        .rd_en    (rk_rd_en && keys_valid_q && rd_idx_ok),
        .rd_idx   (rd_idx_eff),
        .rd_data  (rk_rd_data),
        .rd_valid (rk_rd_valid)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign keys_valid = keys_valid_q;
    assign kx_key     = kx_key_q;
    assign kx_times   = kx_times_q;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// tb/tb_key_sched_ctrl.sv - directed self-checking bench for key_sched_ctrl with an AES key-expansion model
module tb_key_sched_ctrl;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic [127:0] kx_key;
    logic [3:0]   kx_times;
    logic [127:0] kx_keyout;
    logic         rk_rd_en;
    logic [3:0]   rk_rd_idx;
    logic         rk_rev;
    logic [127:0] rk_rd_data;
    logic         rk_rd_valid;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_A_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KEY_A_RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_B    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B_RA = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    key_sched_ctrl #(.KX_LAT(1), .NR(10)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .key_in      (key_in),
        .busy        (busy),
        .done        (done),
        .keys_valid  (keys_valid),
        .kx_key      (kx_key),
        .kx_times    (kx_times),
        .kx_keyout   (kx_keyout),
        .rk_rd_en    (rk_rd_en),
        .rk_rd_idx   (rk_rd_idx),
`ifdef KEY_SCHED_DECRYPT_EN
        .rk_rev      (rk_rev),
`endif
        .rk_rd_data  (rk_rd_data),
        .rk_rd_valid (rk_rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] e   = 8'd254;
        logic [7:0] inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gmul(inv, inv);
            if (e[i]) inv = gmul(inv, a);
        end
        if (a == 8'h00) inv = 8'h00;
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_next(input logic [127:0] k, input logic [3:0] t);
        logic [31:0] w0 = k[127:96];
        logic [31:0] w1 = k[95:64];
        logic [31:0] w2 = k[63:32];
        logic [31:0] w3 = k[31:0];
        logic [31:0] rot = {k[23:0], k[31:24]};
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 1; i < int'(t); i++) rc = xt(rc);
        tmp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
        w0 = w0 ^ tmp;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // One-stage registered expansion datapath (KX_LAT = 1).
    always @(posedge clk) begin
        kx_keyout <= aes_next(kx_key, kx_times);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd_check(input string tag, input logic [3:0] idx, input logic rev,
                            input logic exp_v, input logic [127:0] exp_d);
        @(negedge clk);
        rk_rd_en  = 1'b1;
        rk_rd_idx = idx;
        rk_rev    = rev;
        @(negedge clk);
        rk_rd_en  = 1'b0;
        rk_rev    = 1'b0;
        check({tag, "_v"}, {127'd0, rk_rd_valid}, {127'd0, exp_v});
        check({tag, "_d"}, rk_rd_data, exp_d);
    endtask

    // stress: read while busy and a second start during RUN.
    task automatic run_sched(input string tag, input logic [127:0] key, input bit stress);
        int done_k = 0;
        @(negedge clk);
        key_in = key;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        key_in = '0;
        check({tag, "_kx_times1"}, {124'd0, kx_times}, 128'd1);
        check({tag, "_kx_key0"}, kx_key, key);
        check({tag, "_kv_clear"}, {127'd0, keys_valid}, 128'd0);
        for (int k = 1; k <= 40 && done_k == 0; k++) begin
            if (stress && k == 3) begin
                rk_rd_en  = 1'b1;
                rk_rd_idx = 4'd0;
            end
            if (stress && k == 5) begin
                start  = 1'b1;
                key_in = KEY_B;
            end
            @(negedge clk);
            rk_rd_en = 1'b0;
            start    = 1'b0;
            key_in   = '0;
            if (stress && k == 3) begin
                check({tag, "_busy_rd_v"}, {127'd0, rk_rd_valid}, 128'd0);
                check({tag, "_busy_rd_d"}, rk_rd_data, 128'd0);
            end
            if (done) done_k = k;
            else if (busy !== 1'b1) check({tag, "_busy_run"}, {127'd0, busy}, 128'd1);
        end
        check({tag, "_done_cycle"}, 128'(done_k), 128'd20);
        check({tag, "_busy_at_done"}, {127'd0, busy}, 128'd0);
        check({tag, "_kv_at_done"}, {127'd0, keys_valid}, 128'd1);
        check({tag, "_kx_times_end"}, {124'd0, kx_times}, 128'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, {127'd0, done}, 128'd0);
    endtask

    initial begin
        logic [127:0] mk;
        rst_n     = 1'b0;
        start     = 1'b0;
        key_in    = '0;
        rk_rd_en  = 1'b0;
        rk_rd_idx = '0;
        rk_rev    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_done", {127'd0, done}, 128'd0);
        check("rst_kv", {127'd0, keys_valid}, 128'd0);
        check("rst_rd_v", {127'd0, rk_rd_valid}, 128'd0);
        check("rst_rd_d", rk_rd_data, 128'd0);
        check("rst_kx_key", kx_key, 128'd0);
        check("rst_kx_times", {124'd0, kx_times}, 128'd0);
        rst_n = 1'b1;
        rd_check("idle_rd", 4'd0, 1'b0, 1'b0, 128'd0);

        run_sched("runA", KEY_A, 1'b1);
        rd_check("a_idx0", 4'd0, 1'b0, 1'b1, KEY_A);
        rd_check("a_idx1", 4'd1, 1'b0, 1'b1, KEY_A_R1);
        rd_check("a_idx10", 4'd10, 1'b0, 1'b1, KEY_A_RA);
        rd_check("a_idx11", 4'd11, 1'b0, 1'b0, 128'd0);
        rd_check("a_idx15", 4'd15, 1'b0, 1'b0, 128'd0);
        mk = KEY_A;
        for (int i = 1; i <= 10; i++) begin
            mk = aes_next(mk, 4'(i));
            rd_check($sformatf("a_model%0d", i), 4'(i), 1'b0, 1'b1, mk);
        end
`ifdef KEY_SCHED_DECRYPT_EN
        rd_check("a_rev0", 4'd0, 1'b1, 1'b1, KEY_A_RA);
        rd_check("a_rev10", 4'd10, 1'b1, 1'b1, KEY_A);
        rd_check("a_rev11", 4'd11, 1'b1, 1'b0, 128'd0);
`endif

        run_sched("runB", KEY_B, 1'b0);
        rd_check("b_idx10", 4'd10, 1'b0, 1'b1, KEY_B_RA);
        rd_check("b_idx0", 4'd0, 1'b0, 1'b1, KEY_B);

        @(negedge clk);
        key_in = KEY_A;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {127'd0, busy}, 128'd0);
        check("arst_kx_times", {124'd0, kx_times}, 128'd0);
        check("arst_kv", {127'd0, keys_valid}, 128'd0);
        check("arst_kx_key", kx_key, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_check("arst_rd", 4'd1, 1'b0, 1'b0, 128'd0);

        run_sched("runC", KEY_A, 1'b0);
        rd_check("c_idx1", 4'd1, 1'b0, 1'b1, KEY_A_R1);
        rd_check("c_idx10", 4'd10, 1'b0, 1'b1, KEY_A_RA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
